// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state type and default bus/timeout sizes.
// Used by apb_master, the APB slaves and the bench.
package apb_pkg;

   localparam int unsigned ADDR_W_DEF  = 32;
   localparam int unsigned DATA_W_DEF  = 32;
   localparam int unsigned TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; expired flags the wait cycle that reaches LIMIT.
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_DEF
) (
   input  logic pclk,
   input  logic rst,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   logic [15:0] cnt_q;

   always_ff @(posedge pclk or posedge rst) begin
      if (rst)
         cnt_q <= 16'd0;
      else if (clear)
         cnt_q <= 16'd0;
      else if (inc)
         cnt_q <= cnt_q + 16'd1;
   end

   // High in the wait cycle whose increment would bring the count to LIMIT.
   assign expired = inc & (cnt_q == 16'(LIMIT - 1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB initiator: command handshake in, SETUP/ACCESS out, one-cycle response.
// Optional ACCESS timeout abort is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_W         = ADDR_W_DEF,
   parameter int unsigned DATA_W         = DATA_W_DEF,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic                pclk,
   input  logic                rst,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_strb,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   output logic [DATA_W/8-1:0] pstrb,
   input  logic                pready,
   input  logic                pslverr,
   input  logic [DATA_W-1:0]   prdata
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("apb_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   apb_state_e          state_q, state_d;
   logic                psel_d, penable_d, pwrite_d;
   logic [ADDR_W-1:0]   paddr_d;
   logic [DATA_W-1:0]   pwdata_d;
   logic [DATA_W/8-1:0] pstrb_d;
   logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;
   logic [DATA_W-1:0]   rsp_rdata_d;
   logic                done, accept, abort;

   assign done      = (state_q == ST_ACCESS) & pready;
   assign cmd_ready = ~rst & ((state_q == ST_IDLE) | done);
   assign accept    = cmd_valid & cmd_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   logic expired;

   apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .pclk    (pclk),
      .rst     (rst),
      .clear   (state_q == ST_SETUP),
      .inc     ((state_q == ST_ACCESS) & ~pready),
      .expired (expired)
   );

   // expired already implies ACCESS with pready low, so pready always wins.
   assign abort = expired;
`else
   assign abort = 1'b0;
`endif

   // Next state, next APB outputs and next response.
   always_comb begin
      state_d       = state_q;
      pwrite_d      = pwrite;
      paddr_d       = paddr;
      pwdata_d      = pwdata;
      pstrb_d       = pstrb;
      rsp_valid_d   = 1'b0;
      rsp_rdata_d   = rsp_rdata;
      rsp_err_d     = rsp_err;
      rsp_timeout_d = rsp_timeout;

      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (done)
               state_d = accept ? ST_SETUP : ST_IDLE;
            else if (abort)
               state_d = ST_IDLE;
         end
         default:   state_d = ST_IDLE;
      endcase

      if (accept) begin
         pwrite_d = cmd_write;
         paddr_d  = cmd_addr;
         pwdata_d = cmd_write ? cmd_wdata : '0;
         pstrb_d  = cmd_write ? cmd_strb : '0;
      end

      if (done) begin
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = pwrite ? '0 : prdata;
         rsp_err_d     = pslverr;
         rsp_timeout_d = 1'b0;
      end else if (abort) begin
         rsp_valid_d   = 1'b1;
         rsp_rdata_d   = '0;
         rsp_err_d     = 1'b1;
         rsp_timeout_d = 1'b1;
      end

      psel_d    = (state_d != ST_IDLE);
      penable_d = (state_d == ST_ACCESS);
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         psel        <= 1'b0;
         penable     <= 1'b0;
         pwrite      <= 1'b0;
         paddr       <= '0;
         pwdata      <= '0;
         pstrb       <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel        <= psel_d;
         penable     <= penable_d;
         pwrite      <= pwrite_d;
         paddr       <= paddr_d;
         pwdata      <= pwdata_d;
         pstrb       <= pstrb_d;
         rsp_valid   <= rsp_valid_d;
         rsp_rdata   <= rsp_rdata_d;
         rsp_err     <= rsp_err_d;
         rsp_timeout <= rsp_timeout_d;
      end
   end

endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns single-beat command requests from an internal controller (test sequencer or CPU-side bridge) into compliant APB SETUP/ACCESS transfers toward peripheral slaves such as the UART and GPIO blocks. It holds address, data, direction and strobes stable across wait states, samples `pready`/`prdata`/`pslverr`, and returns a one-cycle response. One transfer is in flight at a time; back-to-back commands are supported without an IDLE cycle.

## Interface
- `ADDR_W`, 32: APB address width.
- `DATA_W`, 32: APB data width; `pstrb` width is `DATA_W/8`.
- `TIMEOUT_CYCLES`, 255: maximum ACCESS cycles before abort. Used only when the timeout feature is compiled in; range 1..65535.

Ports:
- `pclk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted on the cycle where `cmd_valid & cmd_ready`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_W: transfer address.
- `cmd_wdata` in DATA_W: write data.
- `cmd_strb` in DATA_W/8: write byte strobes.
- `rsp_valid` out 1: one-cycle response pulse; no backpressure.
- `rsp_rdata` out DATA_W: read data, valid with `rsp_valid` on reads; 0 on writes.
- `rsp_err` out 1: `pslverr` sampled at completion, or timeout abort.
- `rsp_timeout` out 1: abort caused by timeout; tied 0 without the macro.
- `psel`, `penable`, `pwrite` out 1: APB control.
- `paddr` out ADDR_W; `pwdata` out DATA_W; `pstrb` out DATA_W/8.
- `pready`, `pslverr` in 1; `prdata` in DATA_W.

## Operation
- States: IDLE, SETUP, ACCESS. The encoding lives in the package.
- IDLE:
  - `cmd_ready = (state==IDLE) & ~rst`, combinational.
  - On handshake, register `cmd_*` into `paddr`/`pwdata`/`pwrite`/`pstrb`, then go to SETUP.
  - Reads drive `pstrb = 0` and `pwdata = 0`.
- SETUP: `psel=1`, `penable=0`; always one cycle, then ACCESS.
- ACCESS:
  - `psel=1`, `penable=1`.
  - While `pready=0`, hold all APB outputs unchanged (wait states unlimited unless the timeout feature is enabled).
  - On `pready=1`, capture `prdata` (reads only), `pslverr`, and assert `rsp_valid` next cycle.
- Completion without a pending command: go to IDLE, with `psel` and `penable` low next cycle.
- Back-to-back: `cmd_ready` also goes high during the ACCESS cycle where `pready=1`. If `cmd_valid` is high then, the new command is latched and the next state is SETUP directly (`psel` stays 1, `penable` drops to 0).
- A write with `cmd_strb=0` is still issued as a normal transfer.
- `cmd_*` is ignored when `cmd_ready=0`.
- `paddr`, `pwdata`, `pwrite` and `pstrb` change only on command acceptance. They keep their last values in IDLE.

## Timing
- Reset values (all outputs):
  - `psel`, `penable`, `pwrite`: 0.
  - `paddr`, `pwdata`, `pstrb`: 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_err`, `rsp_timeout`: 0.
  - `cmd_ready`: 0 while `rst` is high, 1 in IDLE after release.
- Accept at edge T → SETUP in cycle T+1 → ACCESS in T+2.
- With a zero-wait slave (`pready=1` in T+2), `rsp_valid` is high in T+3. Each wait state adds one cycle.
- Back-to-back throughput: one transfer per 2 cycles with zero-wait slaves.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` hold until the next response. `rsp_valid` is a single-cycle pulse.
- Reset mid-transfer: all outputs return to reset values immediately (async). No response is issued for the aborted transfer.

## Configuration
- Macro: `APB_MASTER_TIMEOUT_EN`.
- Defined:
  - A 16-bit counter clears on entry to ACCESS and increments each ACCESS cycle with `pready=0`.
  - When it reaches `TIMEOUT_CYCLES`, the transfer aborts: `psel` and `penable` drop next cycle, state goes to IDLE, and a response is issued with `rsp_valid=1`, `rsp_err=1`, `rsp_timeout=1`, `rsp_rdata=0`.
  - If `pready` arrives in the same cycle the count is reached, `pready` wins and the transfer completes normally.
- Undefined: no counter, ACCESS waits indefinitely, `rsp_timeout` is tied 0.

## Structure
- Shared package `apb_pkg`:
  - state type (IDLE/SETUP/ACCESS),
  - default `ADDR_W`/`DATA_W` constants,
  - default timeout constant.
- The package is reused by the APB slaves and the bench.
- Sub-module `apb_timeout_cnt` (counter plus compare, `clear`/`inc`/`expired`) is instantiated only under `APB_MASTER_TIMEOUT_EN`.
- The FSM and the APB output registers stay in `apb_master`.

## Test plan
- Write with a zero-wait slave:
  - Stimulus: addr `0x10`, wdata `0xA5`, strb `4'b0001`.
  - Response: `psel` rises at T+1 with `penable=0`, `penable=1` at T+2, `rsp_valid` at T+3 with `rsp_err=0`.
- Read with 3 wait states, slave returning `0x0000_005A`:
  - Response: APB outputs stable across all ACCESS cycles, `rsp_rdata=0x5A` at T+6.
- Back-to-back write then read:
  - Stimulus: `cmd_valid` held high with both commands queued.
  - Response: `psel` never drops between transfers, `penable` low for exactly one cycle, two `rsp_valid` pulses 2 cycles apart.
- Slave error:
  - Stimulus: slave asserts `pslverr=1` with `pready` on a write.
  - Response: `rsp_err=1`, `rsp_timeout=0`, `rsp_rdata=0`.
- Timeout with the macro defined and `TIMEOUT_CYCLES=4`, `pready` held 0:
  - Response: abort after 4 ACCESS cycles with `rsp_err=1` and `rsp_timeout=1`, `psel=0` the next cycle.
  - A repeat run with `pready` rising on cycle 4 completes normally.
- Reset asserted during ACCESS:
  - Response: `psel`, `penable` and `rsp_valid` go 0 immediately with no response issued; after release, `cmd_ready=1` and a new read completes.
